paddle_input_ctrl: RTL and testbench
====================================

Name: paddle_input_ctrl

Overview:
- Front end for the paddle block: turns two raw, bouncing board push-buttons into the clean `up`/`down` level commands the paddle consumes.
- Per button: synchronize, then debounce with a per-button FSM. Then resolve conflicts and latch once per frame, so commands are stable across the paddle's vblank-edge update.
- One instance per player, placed between the board button pins and the paddle.

Parameters:
- DEBOUNCE_CYCLES, 500000: input must be stable for this many clk cycles before the debounced state changes (10 ms at 50 MHz).
- CNT_W, 19: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- AI_DEADBAND, 4: half-width of the dead zone in lines; used only when PADDLE_AI_EN is defined.

Ports:
- clk  in  1  system pixel clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up_raw  in  1  raw up button, asynchronous to clk, active-high.
- btn_down_raw  in  1  raw down button, asynchronous to clk, active-high.
- vblank  in  1  vertical blanking from the VGA timing block.
- up  out  1  frame-latched up command to the paddle.
- down  out  1  frame-latched down command to the paddle.
- up_stable  out  1  debounced up level, for other consumers such as the game FSM serve start.
- down_stable  out  1  debounced down level.

Behaviour:
- Reset: asynchronous, active-low, and applies at any time including mid-debounce.
  - Sync flops, counters, vblank_d, up, down, up_stable and down_stable all go to 0.
  - Both FSMs go to RELEASED.
- Synchronizer: 2-flop chain per raw button; the FSMs see only the second stage.
- Debounce FSM, one per button, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: synced=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: synced=0 -> RELEASED, cnt<=0. Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
  - PRESSED: synced=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: synced=1 -> PRESSED, cnt<=0. Otherwise cnt++; when cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
  - *_stable = 1 in PRESSED and RELEASE_WAIT, else 0.
  - A bounce during either WAIT state discards progress; there is no partial credit.
  - Counter saturates and never wraps.
- Latency from a clean raw edge to a *_stable change: 2 sync cycles + DEBOUNCE_CYCLES cycles + 1 register cycle.
- Conflict resolution:
  - res_up = up_stable & ~down_stable.
  - res_down = down_stable & ~up_stable.
  - Both pressed gives no motion.
- Frame latch:
  - vblank is registered into vblank_d.
  - Falling edge (vblank_d=1, vblank=0) marks the start of active video; on that cycle up<=res_up and down<=res_down.
  - Outputs are held at all other times, so they are stable through the following vblank rising edge, when the paddle samples them.
  - At most one update per frame.
  - A press and release that both fall within one frame window is not seen by the paddle. This is intended.
- vblank held constantly high or low: no falling edge occurs, so the outputs hold their last values.

Optional Feature:
- Macro: PADDLE_AI_EN.
- Defined:
  - Adds input ports ai_en (1 bit), ball_vpos (11 bits) and paddle_center (11 bits).
  - When ai_en=1, buttons are ignored for res_up/res_down; the *_stable outputs still track the buttons.
  - Comparisons use 12-bit zero-extended arithmetic to avoid overflow:
    - res_up = (ball_vpos + AI_DEADBAND < paddle_center).
    - res_down = (ball_vpos > paddle_center + AI_DEADBAND).
    - Otherwise both are 0.
  - The result is latched on the same vblank falling edge.
  - When ai_en=0, behaviour is identical to the undefined case.
- Undefined: the extra ports are absent and the outputs are button-driven only.

Test Plan:
- Use DEBOUNCE_CYCLES=8 for all scenarios.
- Scenario 1: btn_up_raw clean 0->1 at cycle 0 -> up_stable=1 at cycle 11. up stays 0 until the next vblank falling edge, then up=1 and down=0.
- Scenario 2: btn_up_raw high for 5 cycles, low for 1, then high -> up_stable stays 0 until 8 consecutive synced-high cycles after the glitch.
- Scenario 3: both buttons held debounced -> up=0 and down=0 after the next vblank fall. Release down -> up=1 after the following vblank fall.
- Scenario 4: up held debounced, rst_n pulsed low mid-frame asynchronously -> all outputs 0 immediately. After release, up=1 only after a full re-debounce plus a vblank fall.
- Scenario 5: press and release (each debounced) entirely inside one active-video window -> up never asserts. up_stable shows the 1-pulse.
- Scenario 6 (PADDLE_AI_EN, ai_en=1, AI_DEADBAND=4):
  - ball_vpos=100, paddle_center=240 -> up=1.
  - ball_vpos=238, paddle_center=240 -> up=0, down=0.
  - ball_vpos=400, paddle_center=240 -> down=1.
  - Each result appears after the next vblank fall.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
// Paddle input front end: two-flop synchronizers, per-button debounce FSMs,
// up/down conflict resolution and a once-per-frame latch on the vblank falling edge.
// Optional build macro: PADDLE_AI_EN adds ai_en/ball_vpos/paddle_center and an
// auto-tracking command source that replaces the buttons while ai_en=1.

// Debounce FSM for one synchronized button.
//   state        | meaning
//   RELEASED     | button debounced low
//   PRESS_WAIT   | synced high, counting stable cycles toward PRESSED
//   PRESSED      | button debounced high
//   RELEASE_WAIT | synced low, counting stable cycles toward RELEASED
module paddle_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic synced,
  output logic stable
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stable_nxt;

  // State, counter and stable-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RELEASED;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
    end
  end

  // Next-state logic; any bounce in a WAIT state drops back and clears progress.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (synced) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
    stable_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

endmodule

module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
`ifdef PADDLE_AI_EN
  , parameter int AI_DEADBAND   = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up_raw,
  input  logic        btn_down_raw,
  input  logic        vblank,
`ifdef PADDLE_AI_EN
  input  logic        ai_en,
  input  logic [10:0] ball_vpos,
  input  logic [10:0] paddle_center,
`endif
  output logic        up,
  output logic        down,
  output logic        up_stable,
  output logic        down_stable
);

  logic [1:0] up_sync, down_sync;
  logic       vblank_d;
  logic       res_up, res_down;

  // Two-flop synchronizers for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync   <= 2'b00;
      down_sync <= 2'b00;
    end else begin
      up_sync   <= {up_sync[0], btn_up_raw};
      down_sync <= {down_sync[0], btn_down_raw};
    end
  end

  paddle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .synced (up_sync[1]),
    .stable (up_stable)
  );

  paddle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .synced (down_sync[1]),
    .stable (down_stable)
  );

`ifdef PADDLE_AI_EN
  // Zero-extended to 12 bits so adding the dead band cannot overflow.
  logic [11:0] ball_ext, center_ext, band_ext;
  assign ball_ext   = {1'b0, ball_vpos};
  assign center_ext = {1'b0, paddle_center};
  assign band_ext   = 12'(AI_DEADBAND);
`endif

  // Command resolution: both buttons held cancel to no motion.
  always_comb begin
    res_up   = up_stable & ~down_stable;
    res_down = down_stable & ~up_stable;
`ifdef PADDLE_AI_EN
    if (ai_en) begin
      res_up   = (ball_ext + band_ext) < center_ext;
      res_down = ball_ext > (center_ext + band_ext);
    end
`endif
  end

  // Latch commands once per frame at the start of active video.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_d <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
    end else begin
      vblank_d <= vblank;
      if (vblank_d && !vblank) begin
        up   <= res_up;
        down <= res_down;
      end
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with DEBOUNCE_CYCLES=8.
module tb_paddle_input_ctrl;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up_raw, btn_down_raw, vblank;
  logic up, down, up_stable, down_stable;
`ifdef PADDLE_AI_EN
  logic        ai_en;
  logic [10:0] ball_vpos, paddle_center;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .vblank       (vblank),
`ifdef PADDLE_AI_EN
    .ai_en        (ai_en),
    .ball_vpos    (ball_vpos),
    .paddle_center(paddle_center),
`endif
    .up           (up),
    .down         (down),
    .up_stable    (up_stable),
    .down_stable  (down_stable)
  );

  typedef struct packed {
    logic b_up;
    logic b_dn;
    logic e_up;
    logic e_dn;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One posedge, then settle on the following negedge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // vblank high for two cycles then low; the latch updates on the next edge.
  task automatic frame();
    vblank = 1'b1;
    step(2);
    vblank = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    vblank       = 1'b0;
`ifdef PADDLE_AI_EN
    ai_en         = 1'b0;
    ball_vpos     = '0;
    paddle_center = '0;
`endif
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    vecs[0] = '{b_up:1'b1, b_dn:1'b0, e_up:1'b1, e_dn:1'b0};
    vecs[1] = '{b_up:1'b1, b_dn:1'b1, e_up:1'b0, e_dn:1'b0};
    vecs[2] = '{b_up:1'b0, b_dn:1'b1, e_up:1'b0, e_dn:1'b1};
    vecs[3] = '{b_up:1'b0, b_dn:1'b0, e_up:1'b0, e_dn:1'b0};
    vecs[4] = '{b_up:1'b1, b_dn:1'b1, e_up:1'b0, e_dn:1'b0};
    vecs[5] = '{b_up:1'b1, b_dn:1'b0, e_up:1'b1, e_dn:1'b0};
    vecs[6] = '{b_up:1'b0, b_dn:1'b0, e_up:1'b0, e_dn:1'b0};

    // Reset state.
    do_reset();
    check("rst_up", up, 1'b0);
    check("rst_down", down, 1'b0);
    check("rst_up_stable", up_stable, 1'b0);
    check("rst_down_stable", down_stable, 1'b0);

    // Clean press: stable after 2 + 8 + 1 edges, latched only at vblank fall.
    btn_up_raw = 1'b1;
    step(DB + 2);
    check("s1_stable_early", up_stable, 1'b0);
    step(1);
    check("s1_stable_on_time", up_stable, 1'b1);
    step(3);
    check("s1_up_before_frame", up, 1'b0);
    frame();
    check("s1_up_after_frame", up, 1'b1);
    check("s1_down_after_frame", down, 1'b0);

    // vblank held high: no falling edge, outputs hold even after release.
    vblank = 1'b1;
    btn_up_raw = 1'b0;
    step(DB + 6);
    check("hold_stable_released", up_stable, 1'b0);
    check("hold_up_kept", up, 1'b1);
    vblank = 1'b0;
    step(1);
    check("hold_up_updated", up, 1'b0);

    // Table: debounce each button pattern, then latch through a frame.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      btn_up_raw   = vecs[i].b_up;
      btn_down_raw = vecs[i].b_dn;
      step(DB + 4);
      check($sformatf("tbl%0d_up_stable", i), up_stable, vecs[i].b_up);
      check($sformatf("tbl%0d_down_stable", i), down_stable, vecs[i].b_dn);
      frame();
      check($sformatf("tbl%0d_up", i), up, vecs[i].e_up);
      check($sformatf("tbl%0d_down", i), down, vecs[i].e_dn);
    end

    // Glitch mid-count discards progress.
    do_reset();
    btn_up_raw = 1'b1;
    step(5);
    btn_up_raw = 1'b0;
    step(1);
    btn_up_raw = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < DB + 2; k++) begin
      step(1);
      seen = seen | up_stable;
    end
    check("s2_no_early_stable", seen, 1'b0);
    step(1);
    check("s2_stable_after_8", up_stable, 1'b1);

    // Asynchronous reset mid-frame, then full re-debounce.
    frame();
    check("s4_up_before_rst", up, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s4_up_async_rst", up, 1'b0);
    check("s4_stable_async_rst", up_stable, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(DB + 2);
    check("s4_stable_redebounce_early", up_stable, 1'b0);
    step(1);
    check("s4_stable_redebounce", up_stable, 1'b1);
    check("s4_up_waits_frame", up, 1'b0);
    frame();
    check("s4_up_after_frame", up, 1'b1);

    // Press and release inside one active-video window.
    do_reset();
    btn_up_raw = 1'b1;
    step(DB + 3);
    check("s5_stable_pulse_hi", up_stable, 1'b1);
    btn_up_raw = 1'b0;
    step(DB + 3);
    check("s5_stable_pulse_lo", up_stable, 1'b0);
    check("s5_up_not_seen", up, 1'b0);
    frame();
    check("s5_up_after_frame", up, 1'b0);

`ifdef PADDLE_AI_EN
    // Auto-tracking overrides buttons; stable outputs still follow buttons.
    do_reset();
    btn_down_raw = 1'b1;
    step(DB + 4);
    ai_en = 1'b1;
    paddle_center = 11'd240;
    ball_vpos = 11'd100;
    frame();
    check("ai_100_up", up, 1'b1);
    check("ai_100_down", down, 1'b0);
    check("ai_down_stable", down_stable, 1'b1);
    ball_vpos = 11'd238;
    frame();
    check("ai_238_up", up, 1'b0);
    check("ai_238_down", down, 1'b0);
    ball_vpos = 11'd400;
    frame();
    check("ai_400_up", up, 1'b0);
    check("ai_400_down", down, 1'b1);
    ball_vpos = 11'd236;
    frame();
    check("ai_236_up", up, 1'b0);
    ball_vpos = 11'd235;
    frame();
    check("ai_235_up", up, 1'b1);
    ball_vpos = 11'd244;
    frame();
    check("ai_244_down", down, 1'b0);
    ball_vpos = 11'd245;
    frame();
    check("ai_245_down", down, 1'b1);
    ball_vpos = 11'd2047;
    paddle_center = 11'd2047;
    frame();
    check("ai_wide_up", up, 1'b0);
    check("ai_wide_down", down, 1'b0);
    ai_en = 1'b0;
    frame();
    check("ai_off_down", down, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
